imm_decode_stage: RTL and testbench

//   Registered, handshaked immediate-decode stage for the decode pipe. Extracts the sign- and

---
 rtl/imm_pkg.sv | 16 +
 rtl/imm_extract.sv | 77 +++++++
 rtl/imm_decode_stage.sv | 98 +++++++++
 tb/tb_imm_decode_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-decode stage.
// Format codes and FIFO sizing.
package imm_pkg;

    localparam logic [2:0] ITYPE_R  = 3'b000;
    localparam logic [2:0] ITYPE_I  = 3'b001;
    localparam logic [2:0] ITYPE_B  = 3'b010;
    localparam logic [2:0] ITYPE_S  = 3'b011;
    localparam logic [2:0] ITYPE_U  = 3'b100;
    localparam logic [2:0] ITYPE_J  = 3'b101;
    localparam logic [2:0] ITYPE_Z  = 3'b110;
    localparam logic [2:0] ITYPE_SH = 3'b111;

    localparam int IMM_FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for all RV32I/RV64I formats.
// Produces sign- and zero-extended forms plus legality.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      itype,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] simm,
    output logic [XLEN-1:0] uimm,
    output logic            hasimm,
    output logic            illeg
);

    logic [11:0] i_imm;
    logic [11:0] s_imm;
    logic [12:0] b_imm;
    logic [20:0] j_imm;
    logic [31:0] u_imm;
    logic        unused_opcode;

    assign i_imm = instr[31:20];
    assign s_imm = {instr[31:25], instr[11:7]};
    assign b_imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign u_imm = {instr[31:12], 12'd0};
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        simm   = '0;
        uimm   = '0;
        hasimm = 1'b1;
        illeg  = 1'b0;
        unique case (itype)
            ITYPE_R: begin
                hasimm = 1'b0;
            end
            ITYPE_I: begin
                simm = XLEN'($signed(i_imm));
                uimm = XLEN'(i_imm);
            end
            ITYPE_S: begin
                simm = XLEN'($signed(s_imm));
                uimm = XLEN'(s_imm);
            end
            ITYPE_B: begin
                simm = XLEN'($signed(b_imm));
                uimm = XLEN'(b_imm);
            end
            ITYPE_J: begin
                simm = XLEN'($signed(j_imm));
                uimm = XLEN'(j_imm);
            end
            ITYPE_U: begin
                simm = XLEN'($signed(u_imm));
                uimm = XLEN'(u_imm);
            end
            ITYPE_Z: begin
                simm = XLEN'(instr[19:15]);
                uimm = XLEN'(instr[19:15]);
            end
            ITYPE_SH: begin
                // RV32 has 5-bit shamts; bit 25 set is reserved there
                if (XLEN == 64) begin
                    simm = XLEN'(instr[25:20]);
                    uimm = XLEN'(instr[25:20]);
                end else begin
                    simm  = XLEN'(instr[24:20]);
                    uimm  = XLEN'(instr[24:20]);
                    illeg = instr[25];
                end
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry skid FIFO.
// Extraction happens at the input; outputs come from the head entry.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_itype,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_simm,
    output logic [XLEN-1:0]  out_uimm,
    output logic             out_hasimm,
    output logic             out_illeg,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  simm;
        logic [XLEN-1:0]  uimm;
        logic             hasimm;
        logic             illeg;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t     mem [IMM_FIFO_DEPTH];
    entry_t     wr_entry;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .itype (in_itype),
        .instr (in_instr),
        .simm  (wr_entry.simm),
        .uimm  (wr_entry.uimm),
        .hasimm(wr_entry.hasimm),
        .illeg (wr_entry.illeg)
    );

    assign wr_entry.tag = in_tag;

    assign in_ready  = (count < 2'(IMM_FIFO_DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMM_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_simm   = mem[rd_ptr].simm;
    assign out_uimm   = mem[rd_ptr].uimm;
    assign out_hasimm = mem[rd_ptr].hasimm;
    assign out_illeg  = mem[rd_ptr].illeg;
    assign out_tag    = mem[rd_ptr].tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Randomized and directed bench for imm_decode_stage (XLEN 32 and 64).
// A queue-based reference model predicts every head entry.
module tb_imm_decode_stage;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [2:0]       in_itype = 3'd0;
    logic [31:0]      in_instr = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;

    logic             rdy32, rdy64, ov32, ov64;
    logic [31:0]      s32, u32;
    logic [63:0]      s64, u64;
    logic             h32, h64, il32, il64;
    logic [TAG_W-1:0] t32, t64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_itype(in_itype), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready),
        .out_simm(s32), .out_uimm(u32),
        .out_hasimm(h32), .out_illeg(il32), .out_tag(t32)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_itype(in_itype), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready),
        .out_simm(s64), .out_uimm(u64),
        .out_hasimm(h64), .out_illeg(il64), .out_tag(t64)
    );

    typedef struct {
        logic [63:0]      s32, u32, s64, u64;
        bit               h, il32, il64;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Field value and width from the format table, then arithmetic extension
    function automatic void ref_imm(input logic [2:0] t, input logic [31:0] i,
                                    input int xlen, output logic [63:0] s,
                                    output logic [63:0] u, output bit h,
                                    output bit il);
        logic [63:0] f;
        int          w;
        bit          sgn;
        f = 0; w = 1; sgn = 0; h = 1; il = 0;
        case (t)
            3'd0: h = 0;
            3'd1: begin f = 64'(i[31:20]); w = 12; sgn = 1; end
            3'd3: begin f = 64'({i[31:25], i[11:7]}); w = 12; sgn = 1; end
            3'd2: begin
                f = 64'({i[31], i[7], i[30:25], i[11:8], 1'b0}); w = 13; sgn = 1;
            end
            3'd5: begin
                f = 64'({i[31], i[19:12], i[20], i[30:21], 1'b0}); w = 21; sgn = 1;
            end
            3'd4: begin f = 64'(i[31:12]) * 4096; w = 32; sgn = 1; end
            3'd6: f = 64'(i[19:15]);
            default: begin
                if (xlen == 64) f = 64'(i[25:20]);
                else begin f = 64'(i[24:20]); il = i[25]; end
            end
        endcase
        u = f;
        s = (sgn && f[w-1]) ? f - (64'd1 << w) : f;
        if (xlen == 32) begin
            s = s & 64'hFFFF_FFFF;
            u = u & 64'hFFFF_FFFF;
        end
    endfunction

    task automatic step(input bit v, input logic [2:0] t, input logic [31:0] ins,
                        input logic [TAG_W-1:0] tg, input bit rdy, input bit fl,
                        output bit acc);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = v; in_itype = t; in_instr = ins; in_tag = tg;
        out_ready = rdy; flush = fl;
        #1;
        n = q.size();
        check("in_ready32", rdy32, n < 2);
        check("in_ready64", rdy64, n < 2);
        check("out_valid32", ov32, n != 0);
        check("out_valid64", ov64, n != 0);
        if (n != 0) begin
            e = q[0];
            check("simm32", s32, e.s32);
            check("uimm32", u32, e.u32);
            check("simm64", s64, e.s64);
            check("uimm64", u64, e.u64);
            check("hasimm32", h32, e.h);
            check("hasimm64", h64, e.h);
            check("illeg32", il32, e.il32);
            check("illeg64", il64, e.il64);
            check("tag32", t32, e.tag);
            check("tag64", t64, e.tag);
        end
        acc = !fl && v && n < 2;
        if (fl) begin
            q.delete();
        end else begin
            if (rdy && n != 0) void'(q.pop_front());
            if (acc) begin
                ref_imm(t, ins, 32, e.s32, e.u32, e.h, e.il32);
                ref_imm(t, ins, 64, e.s64, e.u64, e.h, e.il64);
                e.tag = tg;
                q.push_back(e);
            end
        end
    endtask

    initial begin
        bit          acc;
        bit          hold;
        logic [2:0]  ht;
        logic [31:0] hi;
        logic [7:0]  hg;
        int          guard;

        #2;
        check("rst_valid", ov32, 0);
        check("rst_ready", rdy32, 1);
        check("rst_simm", s64, 0);
        check("rst_tag", t32, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed format values
        step(1, 3'd1, 32'hFFF00093, 8'd1, 0, 0, acc);
        step(0, 3'd0, 32'd0, 8'd0, 0, 0, acc);
        check("t1_simm", s32, 32'hFFFF_FFFF);
        check("t1_uimm", u32, 32'h0000_0FFF);
        check("t1_has", h32, 1);
        step(0, 3'd0, 32'd0, 8'd0, 1, 0, acc);
        step(1, 3'd2, 32'hFE000EE3, 8'd2, 0, 0, acc);
        step(0, 3'd0, 32'd0, 8'd0, 0, 0, acc);
        check("t2_simm", s32, 32'hFFFF_FFFC);
        check("t2_uimm", u32, 32'h0000_1FFC);
        step(1, 3'd4, 32'h800000B7, 8'd3, 1, 0, acc);
        step(0, 3'd0, 32'd0, 8'd0, 0, 0, acc);
        check("t3_simm64", s64, 64'hFFFF_FFFF_8000_0000);
        check("t3_uimm64", u64, 64'h0000_0000_8000_0000);
        step(1, 3'd7, 32'h02000093, 8'd4, 1, 0, acc);
        step(0, 3'd0, 32'd0, 8'd0, 0, 0, acc);
        check("t3_sh_ill64", il64, 0);
        check("t3_sh_amt64", s64, 64'd32);
        check("t3_sh_ill32", il32, 1);
        step(1, 3'd0, 32'h00B50533, 8'd5, 1, 0, acc);
        step(0, 3'd0, 32'd0, 8'd0, 0, 0, acc);
        check("t3_r_has", h64, 0);
        check("t3_r_simm", s64, 0);
        step(0, 3'd0, 32'd0, 8'd0, 1, 0, acc);

        // Back-pressure: third push must stall then drain in order
        step(1, 3'd1, 32'h00100093, 8'd1, 0, 0, acc);
        step(1, 3'd1, 32'h00200093, 8'd2, 0, 0, acc);
        step(1, 3'd1, 32'h00300093, 8'd3, 0, 0, acc);
        check("t4_stall", acc, 0);
        check("t4_ready", rdy32, 0);
        guard = 0;
        acc = 0;
        while (!acc && guard < 8) begin
            step(1, 3'd1, 32'h00300093, 8'd3, 1, 0, acc);
            guard++;
        end
        check("t4_accept", acc, 1);
        for (int k = 0; k < 3; k++) step(0, 3'd0, 32'd0, 8'd0, 1, 0, acc);
        check("t4_empty", ov32, 0);

        // Flush at count=2 with a concurrent push
        step(1, 3'd5, 32'h0040006F, 8'd7, 0, 0, acc);
        step(1, 3'd5, 32'h0080006F, 8'd8, 0, 0, acc);
        step(1, 3'd3, 32'hFE112E23, 8'd9, 0, 1, acc);
        step(0, 3'd0, 32'd0, 8'd0, 1, 0, acc);
        check("t5_valid", ov32, 0);
        check("t5_ready", rdy64, 1);
        step(0, 3'd0, 32'd0, 8'd0, 1, 0, acc);

        // Async reset mid-stream
        step(1, 3'd6, 32'h000FD073, 8'h33, 0, 0, acc);
        step(0, 3'd0, 32'd0, 8'd0, 0, 0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", ov32, 0);
        check("t6_tag", t64, 0);
        check("t6_simm", s32, 0);
        check("t6_has", h32, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3'd6, 32'h000FD073, 8'h5A, 0, 0, acc);
        step(0, 3'd0, 32'd0, 8'd0, 0, 0, acc);
        check("t6_newtag", t32, 8'h5A);
        step(0, 3'd0, 32'd0, 8'd0, 1, 0, acc);

        // Random traffic, holding data stable while stalled
        hold = 0; ht = 0; hi = 0; hg = 0;
        for (int c = 0; c < 600; c++) begin
            bit v, r, f;
            f = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 2) != 0);
            if (hold) begin
                v = 1;
            end else begin
                v  = ($urandom_range(0, 3) != 0);
                ht = 3'($urandom_range(0, 7));
                hi = $urandom;
                hg = 8'($urandom);
            end
            step(v, ht, hi, hg, r, f, acc);
            hold = v && !acc && !f;
        end
        for (int k = 0; k < 4; k++) step(0, 3'd0, 32'd0, 8'd0, 1, 0, acc);
        check("final_empty", ov64, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
